// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous-read memory between the fetch (IF) and
// data (DM) requesters and steers each read response back to its owner.
module mem_port_arbiter #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int MAX_WAIT   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [XLEN-1:0]       if_rdata_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [ADDR_WIDTH-1:0] dm_addr_i,
   input  logic [XLEN-1:0]       dm_wdata_i,
   output logic                  dm_gnt_o,
   output logic                  dm_rvalid_o,
   output logic [XLEN-1:0]       dm_rdata_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [XLEN-1:0]       mem_wdata_o,
   input  logic [XLEN-1:0]       mem_rdata_i
);

   typedef enum logic [1:0] {
      OwnerNone = 2'b00,
      OwnerIf   = 2'b01,
      OwnerDm   = 2'b10
   } owner_t;

   localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

   owner_t     owner;
   owner_t     ownerNext;
   logic [3:0] waitCnt;
   logic [3:0] waitCntNext;
   logic       ifWin;
   logic       dmWin;

   // DM has priority unless IF has been starved for MAX_WAIT cycles; nothing is granted in reset.
   always_comb begin
      ifWin = 1'b0;
      dmWin = 1'b0;
      if (rst_n) begin
         if (if_req_i && (!dm_req_i || waitCnt == MaxWaitCnt)) begin
            ifWin = 1'b1;
         end else if (dm_req_i) begin
            dmWin = 1'b1;
         end
      end
   end

   assign if_gnt_o = ifWin;
   assign dm_gnt_o = dmWin;

   always_comb begin
      mem_en_o    = ifWin | dmWin;
      mem_we_o    = dmWin & dm_we_i;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (ifWin) begin
         mem_addr_o = if_addr_i;
      end else if (dmWin) begin
         mem_addr_o  = dm_addr_i;
         mem_wdata_o = dm_wdata_i;
      end
   end

   // Only reads create an owner; writes complete at grant and never return data.
   always_comb begin
      ownerNext = OwnerNone;
      if (ifWin) begin
         ownerNext = OwnerIf;
      end else if (dmWin && !dm_we_i) begin
         ownerNext = OwnerDm;
      end
   end

   always_comb begin
      waitCntNext = waitCnt;
      if (!if_req_i || ifWin) begin
         waitCntNext = '0;
      end else if (waitCnt < MaxWaitCnt) begin
         waitCntNext = waitCnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner   <= OwnerNone;
         waitCnt <= '0;
      end else begin
         owner   <= ownerNext;
         waitCnt <= waitCntNext;
      end
   end

   assign if_rvalid_o = (owner == OwnerIf);
   assign dm_rvalid_o = (owner == OwnerDm);
   assign if_rdata_o  = (owner == OwnerIf) ? mem_rdata_i : '0;
   assign dm_rdata_o  = (owner == OwnerDm) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a memory stub answers the DUT while a request-level model
// predicts grants, memory signals and routed read data every cycle.
module tb_mem_port_arbiter;

   localparam int AW   = 9;
   localparam int MAXW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ifReq;
   logic [AW-1:0] ifAddr;
   logic          ifGnt;
   logic          ifRvalid;
   logic [31:0]   ifRdata;
   logic          dmReq;
   logic          dmWe;
   logic [AW-1:0] dmAddr;
   logic [31:0]   dmWdata;
   logic          dmGnt;
   logic          dmRvalid;
   logic [31:0]   dmRdata;
   logic          memEn;
   logic          memWe;
   logic [AW-1:0] memAddr;
   logic [31:0]   memWdata;
   logic [31:0]   memRdata = 32'h0;

   logic [31:0]   stubMem [0:511];
   logic [31:0]   refMem  [0:511];

   int            checkCount = 0;
   int            passCount  = 0;

   int            mWait = 0;
   int            mPend = 0;
   logic [31:0]   mPendData = 32'h0;
   logic          prevIfReq = 1'b0;
   logic          prevIfGnt = 1'b0;
   logic [AW-1:0] prevIfAddr = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.XLEN(32), .ADDR_WIDTH(AW), .MAX_WAIT(MAXW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .if_req_i(ifReq),
      .if_addr_i(ifAddr),
      .if_gnt_o(ifGnt),
      .if_rvalid_o(ifRvalid),
      .if_rdata_o(ifRdata),
      .dm_req_i(dmReq),
      .dm_we_i(dmWe),
      .dm_addr_i(dmAddr),
      .dm_wdata_i(dmWdata),
      .dm_gnt_o(dmGnt),
      .dm_rvalid_o(dmRvalid),
      .dm_rdata_o(dmRdata),
      .mem_en_o(memEn),
      .mem_we_o(memWe),
      .mem_addr_o(memAddr),
      .mem_wdata_o(memWdata),
      .mem_rdata_i(memRdata)
   );

   // Memory macro stand-in; returns junk when no read is issued so ungated rdata shows up.
   always @(posedge clk) begin
      if (memEn) begin
         if (memWe) stubMem[memAddr] <= memWdata;
         else       memRdata <= stubMem[memAddr];
      end else begin
         memRdata <= $urandom;
      end
   end

   function automatic logic [31:0] seedWord(input int a);
      return (32'(a) * 32'h9E3779B1) ^ 32'h0F0F1234;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      else
         passCount++;
   endtask

   task automatic compareAll(input logic eIfG, input logic eDmG, input logic eEn, input logic eWe,
                             input logic [AW-1:0] eAddr, input logic [31:0] eWdata,
                             input logic eIfV, input logic eDmV,
                             input logic [31:0] eIfD, input logic [31:0] eDmD);
      checkOutput("ifGnt", 64'(ifGnt), 64'(eIfG));
      checkOutput("dmGnt", 64'(dmGnt), 64'(eDmG));
      checkOutput("memEn", 64'(memEn), 64'(eEn));
      checkOutput("memWe", 64'(memWe), 64'(eWe));
      checkOutput("memAddr", 64'(memAddr), 64'(eAddr));
      checkOutput("memWdata", 64'(memWdata), 64'(eWdata));
      checkOutput("ifRvalid", 64'(ifRvalid), 64'(eIfV));
      checkOutput("dmRvalid", 64'(dmRvalid), 64'(eDmV));
      checkOutput("ifRdata", 64'(ifRdata), 64'(eIfD));
      checkOutput("dmRdata", 64'(dmRdata), 64'(eDmD));
   endtask

   task automatic applyStimulus(input logic r, input logic [AW-1:0] a, input logic dr, input logic dw,
                                input logic [AW-1:0] da, input logic [31:0] dd);
      ifReq   = r;
      ifAddr  = a;
      dmReq   = dr;
      dmWe    = dw;
      dmAddr  = da;
      dmWdata = dd;
   endtask

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   // Request-level reference: priority with a starvation budget, one-cycle read return.
   initial begin
      logic          expIf;
      logic          expDm;
      logic [AW-1:0] expAddr;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            compareAll(1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            mWait = 0;
            mPend = 0;
         end else begin
            if (prevIfReq && !prevIfGnt && ifReq && ifAddr != prevIfAddr)
               $error("[TB] held IF address changed before grant");
            expIf   = ifReq && (!dmReq || mWait == MAXW);
            expDm   = dmReq && !expIf;
            expAddr = expIf ? ifAddr : (expDm ? dmAddr : '0);
            compareAll(expIf, expDm, expIf || expDm, expDm && dmWe, expAddr,
                       expDm ? dmWdata : 32'h0,
                       mPend == 1, mPend == 2,
                       (mPend == 1) ? mPendData : 32'h0,
                       (mPend == 2) ? mPendData : 32'h0);
            if (expIf) begin
               mPend = 1;
               mPendData = refMem[ifAddr];
            end else if (expDm && !dmWe) begin
               mPend = 2;
               mPendData = refMem[dmAddr];
            end else begin
               mPend = 0;
            end
            if (expDm && dmWe) refMem[dmAddr] = dmWdata;
            if (!ifReq || expIf) mWait = 0;
            else mWait = (mWait + 1 > MAXW) ? MAXW : mWait + 1;
         end
         prevIfReq  = ifReq;
         prevIfGnt  = ifGnt;
         prevIfAddr = ifAddr;
      end
   end

   initial begin
      logic gi;
      logic gd;
      for (int a = 0; a < 512; a++) begin
         stubMem[a] = seedWord(a);
         refMem[a]  = seedWord(a);
      end
      stubMem[4]  = 32'h00500093;  refMem[4]  = 32'h00500093;
      stubMem[8]  = 32'h00000813;  refMem[8]  = 32'h00000813;
      stubMem[16] = 32'hCAFE0010;  refMem[16] = 32'hCAFE0010;

      rst_n = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 32'h0);
      #1 applyStimulus(1'b1, 9'h004, 1'b1, 1'b0, 9'h010, 32'h0);
      @(negedge clk);
      #1;
      checkOutput("rstIfGnt", 64'(ifGnt), 64'd0);
      checkOutput("rstDmGnt", 64'(dmGnt), 64'd0);
      checkOutput("rstMemEn", 64'(memEn), 64'd0);

      // IF alone right after reset release.
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, 9'h004, 1'b0, 1'b0, '0, 32'h0);
      #1;
      checkOutput("t1IfGnt", 64'(ifGnt), 64'd1);
      checkOutput("t1MemEn", 64'(memEn), 64'd1);
      checkOutput("t1MemAddr", 64'(memAddr), 64'h004);
      nextCycle;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 32'h0);
      #1;
      checkOutput("t1IfRvalid", 64'(ifRvalid), 64'd1);
      checkOutput("t1IfRdata", 64'(ifRdata), 64'h00500093);
      checkOutput("t1DmRvalid", 64'(dmRvalid), 64'd0);

      // Both read: DM first, IF next.
      nextCycle;
      applyStimulus(1'b1, 9'h008, 1'b1, 1'b0, 9'h010, 32'h0);
      #1;
      checkOutput("t2DmGnt", 64'(dmGnt), 64'd1);
      checkOutput("t2IfGnt", 64'(ifGnt), 64'd0);
      nextCycle;
      applyStimulus(1'b1, 9'h008, 1'b0, 1'b0, '0, 32'h0);
      #1;
      checkOutput("t2DmRvalid", 64'(dmRvalid), 64'd1);
      checkOutput("t2DmRdata", 64'(dmRdata), 64'hCAFE0010);
      checkOutput("t2IfGntLate", 64'(ifGnt), 64'd1);
      nextCycle;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 32'h0);
      #1;
      checkOutput("t2IfRvalid", 64'(ifRvalid), 64'd1);
      checkOutput("t2IfRdata", 64'(ifRdata), 64'h00000813);

      // DM write racing an IF read of the same word.
      nextCycle;
      applyStimulus(1'b1, 9'h020, 1'b1, 1'b1, 9'h020, 32'hDEADBEEF);
      #1;
      checkOutput("t3MemWe", 64'(memWe), 64'd1);
      checkOutput("t3MemWdata", 64'(memWdata), 64'hDEADBEEF);
      checkOutput("t3DmGnt", 64'(dmGnt), 64'd1);
      checkOutput("t3IfGnt", 64'(ifGnt), 64'd0);
      nextCycle;
      applyStimulus(1'b1, 9'h020, 1'b0, 1'b0, '0, 32'h0);
      #1;
      checkOutput("t3IfRvalidW", 64'(ifRvalid), 64'd0);
      checkOutput("t3DmRvalidW", 64'(dmRvalid), 64'd0);
      checkOutput("t3IfGnt2", 64'(ifGnt), 64'd1);
      nextCycle;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 32'h0);
      #1;
      checkOutput("t3IfRvalid", 64'(ifRvalid), 64'd1);
      checkOutput("t3IfRdata", 64'(ifRdata), 64'hDEADBEEF);

      // Both held: IF forced through after MAX_WAIT denials.
      nextCycle;
      applyStimulus(1'b1, 9'h040, 1'b1, 1'b0, 9'h030, 32'h0);
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("starveIfGnt", 64'(ifGnt), 64'(i == 3));
         checkOutput("starveDmGnt", 64'(dmGnt), 64'(i != 3));
         nextCycle;
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 32'h0);
      nextCycle;

      // Alternating owners every cycle.
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) applyStimulus(1'b1, 9'(9'h050 + k), 1'b0, 1'b0, '0, 32'h0);
         else            applyStimulus(1'b0, '0, 1'b1, 1'b0, 9'(9'h060 + k), 32'h0);
         #1;
         if (k > 0) begin
            checkOutput("altIfRvalid", 64'(ifRvalid), 64'((k - 1) % 2 == 0));
            checkOutput("altDmRvalid", 64'(dmRvalid), 64'((k - 1) % 2 == 1));
         end
         nextCycle;
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 32'h0);
      #1;
      checkOutput("altLastDmRvalid", 64'(dmRvalid), 64'd1);
      checkOutput("altLastIfRvalid", 64'(ifRvalid), 64'd0);
      nextCycle;

      // Asynchronous reset while an IF read is returning.
      applyStimulus(1'b1, 9'h004, 1'b0, 1'b0, '0, 32'h0);
      #1;
      checkOutput("t6IfGnt", 64'(ifGnt), 64'd1);
      nextCycle;
      applyStimulus(1'b1, 9'h008, 1'b1, 1'b0, 9'h010, 32'h0);
      #1;
      checkOutput("t6PreRstRvalid", 64'(ifRvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("t6RstIfRvalid", 64'(ifRvalid), 64'd0);
      checkOutput("t6RstIfRdata", 64'(ifRdata), 64'd0);
      checkOutput("t6RstIfGnt", 64'(ifGnt), 64'd0);
      checkOutput("t6RstDmGnt", 64'(dmGnt), 64'd0);
      checkOutput("t6RstMemEn", 64'(memEn), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, 9'h008, 1'b0, 1'b0, '0, 32'h0);
      #1;
      checkOutput("t6PostRstIfGnt", 64'(ifGnt), 64'd1);
      nextCycle;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 32'h0);

      // Random traffic on a small address window to provoke read-after-write hits.
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         #1;
         gi = ifGnt;
         gd = dmGnt;
         @(posedge clk);
         #1;
         if (!ifReq || gi) begin
            ifReq  = ($urandom_range(99) < 60);
            ifAddr = 9'($urandom_range(31));
         end else if ($urandom_range(99) < 5) begin
            ifReq = 1'b0;
         end
         if (!dmReq || gd) begin
            dmReq   = ($urandom_range(99) < 60);
            dmWe    = 1'($urandom_range(1));
            dmAddr  = 9'($urandom_range(31));
            dmWdata = $urandom;
         end else if ($urandom_range(99) < 5) begin
            dmReq = 1'b0;
         end
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
